seq_div16x8: RTL and testbench



---
 rtl/seq_div16x8_pkg.sv | 24 ++
 rtl/seq_div16x8_if.sv | 25 ++
 rtl/seq_div16x8_sign_mag_conv.sv | 17 +
 rtl/seq_div16x8.sv | 139 +++++++++++++
 tb/tb_seq_div16x8.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_div16x8_pkg.sv
// Shared constants and types for the sequential 16/8 restoring divider.
package seq_div16x8_pkg;

  localparam int unsigned DIV_ITERS = 16;
  localparam int unsigned DVD_W     = 16;
  localparam int unsigned DSR_W     = 8;
  localparam int unsigned QUO_W     = 17;
  localparam int unsigned REM_W     = 9;
  localparam int unsigned CNT_W     = 4;

  // sign_mode bit positions, common with booth_mult8
  localparam int unsigned SM_A_SIGNED = 1;
  localparam int unsigned SM_B_SIGNED = 0;

  localparam logic [QUO_W-1:0] DZ_QUOTIENT  = 17'h1FFFF;
  localparam logic [REM_W-1:0] DZ_REMAINDER = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div16x8_if.sv
// Start/done handshake and operand/result bus between sequencer and divider.
interface seq_div16x8_if;
  import seq_div16x8_pkg::*;

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DSR_W-1:0] divisor;
  logic [1:0]       sign_mode;
  logic [QUO_W-1:0] quotient;
  logic [REM_W-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, sign_mode,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, sign_mode,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/seq_div16x8_sign_mag_conv.sv
// Conditional two's-complement negate with zero-extension: abs() on operands
// when neg_i is the operand sign, signed result from magnitude on outputs.
module seq_div16x8_sign_mag_conv #(
  parameter int unsigned W_IN  = 16,
  parameter int unsigned W_OUT = 16
) (
  input  logic [W_IN-1:0]  data_i,
  input  logic             neg_i,
  output logic [W_OUT-1:0] data_o
);

  logic [W_OUT-1:0] ext_c;

  assign ext_c  = W_OUT'(data_i);
  assign data_o = neg_i ? (~ext_c + W_OUT'(1)) : ext_c;

endmodule

// File: rtl/seq_div16x8.sv
// Sequential radix-2 restoring divider, 16-bit dividend by 8-bit divisor,
// one quotient bit per cycle, sign handled by magnitude conversion around it.
module seq_div16x8
  import seq_div16x8_pkg::*;
#(
  parameter int unsigned ITERS = DIV_ITERS
) (
  input  logic          clk,
  input  logic          rst,
  seq_div16x8_if.slave  bus
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REM_W-1:0] prem_q;
  logic [DVD_W-1:0] dvd_q;
  logic [DSR_W-1:0] dsr_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [QUO_W-1:0] quo_q;
  logic [REM_W-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic             dvd_neg_c;
  logic             dsr_neg_c;
  logic [DVD_W-1:0] dvd_mag_c;
  logic [DSR_W-1:0] dsr_mag_c;
  logic [QUO_W-1:0] quo_c;
  logic [REM_W-1:0] rem_c;
  logic [10:0]      diff_c;
  logic             qbit_c;
  logic [REM_W-1:0] prem_d;
  logic [DVD_W-1:0] dvd_d;

  assign dvd_neg_c = bus.sign_mode[SM_A_SIGNED] & bus.dividend[DVD_W-1];
  assign dsr_neg_c = bus.sign_mode[SM_B_SIGNED] & bus.divisor[DSR_W-1];

  seq_div16x8_sign_mag_conv #(.W_IN(DVD_W), .W_OUT(DVD_W)) u_conv_dvd (
    .data_i (bus.dividend),
    .neg_i  (dvd_neg_c),
    .data_o (dvd_mag_c)
  );

  seq_div16x8_sign_mag_conv #(.W_IN(DSR_W), .W_OUT(DSR_W)) u_conv_dsr (
    .data_i (bus.divisor),
    .neg_i  (dsr_neg_c),
    .data_o (dsr_mag_c)
  );

  seq_div16x8_sign_mag_conv #(.W_IN(DVD_W), .W_OUT(QUO_W)) u_conv_quo (
    .data_i (dvd_q),
    .neg_i  (qneg_q),
    .data_o (quo_c)
  );

  // partial remainder is always below the divisor, so 8 bits hold its magnitude
  seq_div16x8_sign_mag_conv #(.W_IN(DSR_W), .W_OUT(REM_W)) u_conv_rem (
    .data_i (prem_q[DSR_W-1:0]),
    .neg_i  (rneg_q),
    .data_o (rem_c)
  );

  // One restoring step: shift in next dividend bit, trial-subtract divisor
  always_comb begin
    diff_c = {1'b0, prem_q, dvd_q[DVD_W-1]} - 11'(dsr_q);
    qbit_c = ~diff_c[10];
    prem_d = qbit_c ? REM_W'(diff_c) : REM_W'({prem_q, dvd_q[DVD_W-1]});
    dvd_d  = {dvd_q[DVD_W-2:0], qbit_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            dvd_q   <= dvd_mag_c;
            dsr_q   <= dsr_mag_c;
            qneg_q  <= dvd_neg_c ^ dsr_neg_c;
            rneg_q  <= dvd_neg_c;
            prem_q  <= '0;
            cnt_q   <= CNT_W'(ITERS - 1);
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ITER;
          end
        end
        ITER: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          // zero divisor still runs full latency; results forced here
          if (dsr_q == '0) begin
            quo_q <= DZ_QUOTIENT;
            rem_q <= DZ_REMAINDER;
            dbz_q <= 1'b1;
          end else begin
            quo_q <= quo_c;
            rem_q <= rem_c;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div16x8.sv
// Scoreboard bench for seq_div16x8: directed corners, busy/reset handling,
// back-to-back accepts and randomized operands against integer division.
module tb_seq_div16x8;

  typedef struct {
    logic [16:0] q;
    logic [8:0]  r;
    logic        dz;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];

  seq_div16x8_if dut_if ();

  seq_div16x8 dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [16:0] q, input logic [8:0] r, input logic dz);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.acc = 0;
    return e;
  endfunction

  // Reference: integer division truncating toward zero, remainder sign of dividend
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input logic [1:0] sm);
    int ai;
    int bi;
    ai = sm[1] ? int'($signed(a)) : int'(a);
    bi = sm[0] ? int'($signed(b)) : int'(b);
    if (bi == 0) return mk(17'h1FFFF, 9'h000, 1'b1);
    return mk(17'(ai / bi), 9'(ai % bi), 1'b0);
  endfunction

  // Monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (dut_if.done) begin
          chk("done_width", 32'(prev_done), 0);
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_done: got done with empty scoreboard (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("quotient", 32'(dut_if.quotient), 32'(e.q));
            chk("remainder", 32'(dut_if.remainder), 32'(e.r));
            chk("div_by_zero", 32'(dut_if.div_by_zero), 32'(e.dz));
            chk("latency", 32'(cyc - e.acc), 17);
            chk("busy_at_done", 32'(dut_if.busy), 0);
          end
        end
        prev_done = dut_if.done;
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge after accept
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic [1:0] sm, input exp_t e);
    dut_if.start     = 1'b1;
    dut_if.dividend  = a;
    dut_if.divisor   = b;
    dut_if.sign_mode = sm;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    dut_if.start     = 1'b0;
    dut_if.dividend  = 16'($urandom);
    dut_if.divisor   = 8'($urandom);
    dut_if.sign_mode = 2'($urandom);
  endtask

  task automatic wait_done(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = dut_if.done;
    end
    chk(nm, 32'(seen), 1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [1:0] sm, input exp_t e);
    issue(a, b, sm, e);
    wait_done("done_seen");
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_quotient"}, 32'(dut_if.quotient), 0);
    chk({tag, "_remainder"}, 32'(dut_if.remainder), 0);
    chk({tag, "_busy"}, 32'(dut_if.busy), 0);
    chk({tag, "_done"}, 32'(dut_if.done), 0);
    chk({tag, "_dbz"}, 32'(dut_if.div_by_zero), 0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    logic [1:0]  sm;
    logic        idle;
    exp_t        e;
    int          n_acc;
    int          prev_acc;

    dut_if.start     = 1'b0;
    dut_if.dividend  = '0;
    dut_if.divisor   = '0;
    dut_if.sign_mode = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed values from hand arithmetic
    do_op(16'd1000, 8'd7, 2'b00, mk(17'd142, 9'd6, 1'b0));
    do_op(16'hFFF9, 8'h02, 2'b11, mk(17'h1FFFD, 9'h1FF, 1'b0));
    do_op(16'h8000, 8'hFF, 2'b11, mk(17'h08000, 9'h000, 1'b0));
    do_op(16'hFFFF, 8'hFF, 2'b01, mk(17'h10001, 9'h000, 1'b0));
    do_op(16'h8000, 8'h80, 2'b10, mk(17'h1FF00, 9'h000, 1'b0));
    repeat (4) @(negedge clk);
    chk("hold_quotient", 32'(dut_if.quotient), 32'h1FF00);
    chk("hold_done", 32'(dut_if.done), 0);

    // Divide by zero with an ignored start at E5
    issue(16'h1234, 8'h00, 2'b11, mk(17'h1FFFF, 9'h000, 1'b1));
    repeat (4) @(negedge clk);
    dut_if.start     = 1'b1;
    dut_if.dividend  = 16'd1000;
    dut_if.divisor   = 8'd7;
    dut_if.sign_mode = 2'b00;
    @(negedge clk);
    dut_if.start = 1'b0;
    wait_done("dz_done_seen");
    repeat (25) @(negedge clk);
    chk("ignored_quotient", 32'(dut_if.quotient), 32'h1FFFF);
    chk("ignored_remainder", 32'(dut_if.remainder), 0);
    chk("ignored_dbz", 32'(dut_if.div_by_zero), 1);
    chk("ignored_busy", 32'(dut_if.busy), 0);

    // Asynchronous reset at E8 of an operation
    issue(16'd5000, 8'd3, 2'b00, model(16'd5000, 8'd3, 2'b00));
    repeat (8) @(posedge clk);
    chk("midop_busy", 32'(dut_if.busy), 1);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("midop_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(16'd255, 8'd255, 2'b00, mk(17'd1, 9'd0, 1'b0));

    // start held high: accepts every 18 cycles, operands changing every cycle
    n_acc    = 0;
    prev_acc = 0;
    for (int g = 0; g < 200 && n_acc < 6; g++) begin
      if (g > 0) @(negedge clk);
      a  = 16'($urandom);
      b  = 8'($urandom);
      sm = 2'($urandom);
      dut_if.start     = 1'b1;
      dut_if.dividend  = a;
      dut_if.divisor   = b;
      dut_if.sign_mode = sm;
      idle = ~dut_if.busy;
      @(posedge clk);
      #1;
      if (idle) begin
        e = model(a, b, sm);
        e.acc = cyc;
        sb.push_back(e);
        if (n_acc > 0) chk("b2b_spacing", 32'(cyc - prev_acc), 18);
        prev_acc = cyc;
        n_acc++;
      end
    end
    chk("b2b_accepts", 32'(n_acc), 6);
    @(negedge clk);
    dut_if.start = 1'b0;
    wait_done("b2b_done_seen");

    // Random nonzero divisors per mode, then zero divisors per mode
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 500; i++) begin
        a  = 16'($urandom);
        b  = 8'($urandom_range(255, 1));
        sm = 2'(m);
        do_op(a, b, sm, model(a, b, sm));
      end
      for (int i = 0; i < 3; i++) begin
        a  = 16'($urandom);
        sm = 2'(m);
        do_op(a, 8'h00, sm, model(a, 8'h00, sm));
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
